instr_mem_loadable: RTL and testbench

Parametrised, runtime-loadable instruction memory for the RISC core. It replaces the fixed, zero-initialised instruction store. The fetch port keeps the pc-addressed read. A stream-load port with a valid/ready handshake lets a host or boot controller write a program into the array. A tracked program length makes every fetch outside the loaded program, or during a load, return a NOP.

---
 rtl/instr_mem_loadable_pkg.sv | 17 +
 rtl/instr_mem_loadable_imem_array.sv | 31 +++
 rtl/instr_mem_loadable.sv | 143 ++++++++++++++
 tb/tb_instr_mem_loadable.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: load FSM state
// encodings, the default NOP word and the array index-width helper.
package instr_mem_loadable_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE = 2'd0,
      IMEM_LOAD = 2'd1,
      IMEM_DONE = 2'd2
   } imem_state_e;

   localparam logic [15:0] DEFAULT_NOP_WORD = 16'h0000;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instr_mem_loadable_imem_array.sv
// Plain DATA_W x DEPTH RAM: one synchronous write port, one asynchronous read
// port. Kept separate so it can be swapped for a ROM/BRAM macro.
module instr_mem_loadable_imem_array
   import instr_mem_loadable_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 30,
   parameter int IDX_W  = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; a cleared prog_len makes stale words
   // unreachable, and leaving storage unreset lets it map onto RAM macros.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Callers only present raddr < DEPTH when the result is used.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: pc-addressed fetch port plus a
// valid/ready stream-load port; fetches outside the loaded program return NOP.
module instr_mem_loadable
   import instr_mem_loadable_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 30,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD),
   parameter int                REG_READ = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] RD,
   output logic              imem_ready,
   output logic              fetch_err,
   input  logic              load_start,
   input  logic              load_abort,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_ovf,
   output logic [ADDR_W:0]   prog_len
);

   localparam int               IDX_W     = idx_width(DEPTH);
   localparam int               LEN_W     = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

   imem_state_e       state_q, state_d;
   logic [IDX_W-1:0]  wptr_q, wptr_d;
   logic [LEN_W-1:0]  prog_len_q, prog_len_d;
   logic              load_ovf_q, load_ovf_d;
   logic              beat_acc;
   logic              fetch_ok;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rd_d;
   logic              fetch_err_d;

   // NOTE: every always_comb output is defaulted first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      prog_len_d = prog_len_q;
      load_ovf_d = load_ovf_q;
      beat_acc   = 1'b0;
      case (state_q)
         IMEM_IDLE: begin
            if (load_start) begin
               state_d    = IMEM_LOAD;
               wptr_d     = '0;
               prog_len_d = '0;
               load_ovf_d = 1'b0;
            end
         end
         IMEM_LOAD: begin
            // Abort wins over a beat presented in the same cycle.
            if (load_abort) begin
               state_d    = IMEM_IDLE;
               prog_len_d = '0;
            end else if (load_valid) begin
               beat_acc = 1'b1;
               wptr_d   = wptr_q + IDX_W'(1);
               if (load_last) begin
                  state_d    = IMEM_DONE;
                  prog_len_d = LEN_W'(wptr_q) + LEN_W'(1);
               end else if (wptr_q == LAST_IDX) begin
                  state_d    = IMEM_DONE;
                  prog_len_d = DEPTH_LEN;
                  load_ovf_d = 1'b1;
               end
            end
         end
         IMEM_DONE: state_d = IMEM_IDLE;
         default:   state_d = IMEM_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IMEM_IDLE;
         wptr_q     <= '0;
         prog_len_q <= '0;
         load_ovf_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         prog_len_q <= prog_len_d;
         load_ovf_q <= load_ovf_d;
      end
   end

   instr_mem_loadable_imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (beat_acc),
      .waddr (wptr_q),
      .wdata (load_data),
      .raddr (A[IDX_W-1:0]),
      .rdata (mem_rdata)
   );

   assign imem_ready = (state_q != IMEM_LOAD);
   assign load_ready = (state_q == IMEM_LOAD);
   assign load_done  = (state_q == IMEM_DONE);
   assign load_ovf   = load_ovf_q;
   assign prog_len   = prog_len_q;

   // prog_len <= DEPTH, so a passing compare also keeps A inside the array.
   assign fetch_ok    = imem_ready && ({1'b0, A} < prog_len_q);
   assign rd_d        = fetch_ok ? mem_rdata : NOP_WORD;
   assign fetch_err_d = !fetch_ok && imem_ready;

   if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] rd_q;
      logic              fetch_err_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_q        <= NOP_WORD;
            fetch_err_q <= 1'b1;
         end else begin
            rd_q        <= rd_d;
            fetch_err_q <= fetch_err_d;
         end
      end

      assign RD        = rd_q;
      assign fetch_err = fetch_err_q;
   end else begin : g_comb_read
      assign RD        = rd_d;
      assign fetch_err = fetch_err_d;
   end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench: drives one combinational-read and one registered-read
// instance from the same stimulus; a negedge monitor pops expectations.
module tb_instr_mem_loadable;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 30;
   localparam logic [15:0] NOP = 16'h0000;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] rd;
      logic        err;
   } fetch_exp_t;

   typedef struct packed {
      logic       ir;
      logic       lr;
      logic [8:0] pl;
      logic       ovf;
      logic       done;
   } stat_exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] A = '0;
   logic              load_start = 1'b0;
   logic              load_abort = 1'b0;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_last = 1'b0;

   logic [DATA_W-1:0] rd0, rd1;
   logic              ir0, ir1, err0, err1, lr0, lr1, done0, done1, ovf0, ovf1;
   logic [ADDR_W:0]   pl0, pl1;

   fetch_exp_t q_f0[$];
   fetch_exp_t q_f1[$];
   stat_exp_t  q_s[$];

   logic fetch_req = 1'b0;
   logic fetch_req_d = 1'b0;
   logic reg_probe = 1'b0;
   logic stat_req = 1'b0;
   logic end_req = 1'b0;
   logic end_seen = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   done0_cnt = 0;
   int   done1_cnt = 0;

   always #5 clk = ~clk;

   instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                        .NOP_WORD(NOP), .REG_READ(0)) dut0 (
      .clk(clk), .rst(rst), .A(A), .RD(rd0), .imem_ready(ir0), .fetch_err(err0),
      .load_start(load_start), .load_abort(load_abort), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(lr0),
      .load_done(done0), .load_ovf(ovf0), .prog_len(pl0)
   );

   instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                        .NOP_WORD(NOP), .REG_READ(1)) dut1 (
      .clk(clk), .rst(rst), .A(A), .RD(rd1), .imem_ready(ir1), .fetch_err(err1),
      .load_start(load_start), .load_abort(load_abort), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(lr1),
      .load_done(done1), .load_ovf(ovf1), .prog_len(pl1)
   );

   always @(posedge clk) fetch_req_d <= fetch_req;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever a DUT output is due this cycle.
   always @(negedge clk) begin
      fetch_exp_t fe;
      stat_exp_t  se;
      if (done0) done0_cnt++;
      if (done1) done1_cnt++;
      if (fetch_req) begin
         if (q_f0.size() == 0) check("comb_queue_empty", 1, 0);
         else begin
            fe = q_f0.pop_front();
            check($sformatf("comb_rd[A=%0d]", fe.addr), 32'(rd0), 32'(fe.rd));
            check($sformatf("comb_err[A=%0d]", fe.addr), 32'(err0), 32'(fe.err));
         end
      end
      if (fetch_req_d || reg_probe) begin
         if (q_f1.size() == 0) check("reg_queue_empty", 1, 0);
         else begin
            fe = q_f1.pop_front();
            check($sformatf("reg_rd[A=%0d]", fe.addr), 32'(rd1), 32'(fe.rd));
            check($sformatf("reg_err[A=%0d]", fe.addr), 32'(err1), 32'(fe.err));
         end
      end
      if (stat_req) begin
         if (q_s.size() == 0) check("stat_queue_empty", 1, 0);
         else begin
            se = q_s.pop_front();
            check("comb_status{ir,lr,len,ovf,done}", 32'({ir0, lr0, pl0, ovf0, done0}), 32'(se));
            check("reg_status{ir,lr,len,ovf,done}", 32'({ir1, lr1, pl1, ovf1, done1}), 32'(se));
         end
      end
      if (end_req && !end_seen) begin
         end_seen = 1'b1;
         check("comb_done_pulses", 32'(done0_cnt), 32'd3);
         check("reg_done_pulses", 32'(done1_cnt), 32'd3);
         check("fetch_queue_left", 32'(q_f0.size() + q_f1.size()), 32'd0);
         check("stat_queue_left", 32'(q_s.size()), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      fetch_req  = 1'b0;
      reg_probe  = 1'b0;
      stat_req   = 1'b0;
      load_start = 1'b0;
      load_abort = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic expect_fetch(input logic [7:0] a, input logic [15:0] rd, input logic err);
      A = a;
      fetch_req = 1'b1;
      q_f0.push_back('{addr: a, rd: rd, err: err});
      q_f1.push_back('{addr: a, rd: rd, err: err});
   endtask

   task automatic expect_stat(input logic ir, input logic lr, input logic [8:0] pl,
                              input logic ovf, input logic done);
      stat_req = 1'b1;
      q_s.push_back('{ir: ir, lr: lr, pl: pl, ovf: ovf, done: done});
   endtask

   task automatic beat(input logic [15:0] data, input logic last);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
   endtask

   initial begin
      // 1: reset state and empty-program fetches
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      expect_stat(1, 0, 9'd0, 0, 0);
      reg_probe = 1'b1;
      q_f1.push_back('{addr: 8'd0, rd: NOP, err: 1'b1});
      tick();
      for (int i = 0; i < 6; i++) begin
         expect_fetch(8'(i), NOP, 1'b1);
         tick();
      end

      // 2: three-word load; starts inside LOAD and DONE are ignored
      load_start = 1'b1;
      tick();
      expect_stat(0, 1, 9'd0, 0, 0);
      expect_fetch(8'd0, NOP, 1'b0);
      beat(16'h1111, 1'b0);
      tick();
      beat(16'h2222, 1'b0);
      load_start = 1'b1;
      tick();
      beat(16'h3333, 1'b1);
      tick();
      expect_stat(1, 0, 9'd3, 0, 1);
      expect_fetch(8'd2, 16'h3333, 1'b0);
      load_start = 1'b1;
      tick();
      expect_stat(1, 0, 9'd3, 0, 0);
      expect_fetch(8'd1, 16'h2222, 1'b0);
      tick();
      expect_fetch(8'd3, NOP, 1'b1);
      tick();
      expect_fetch(8'd0, 16'h1111, 1'b0);
      tick();
      expect_fetch(8'd200, NOP, 1'b1);
      tick();

      // 3: overflow after DEPTH beats without load_last
      load_start = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 0) expect_stat(0, 1, 9'd0, 0, 0);
         beat(16'hA000 + 16'(i), 1'b0);
         tick();
      end
      expect_stat(1, 0, 9'd30, 1, 1);
      tick();
      beat(16'hBEEF, 1'b0);
      expect_stat(1, 0, 9'd30, 1, 0);
      tick();
      expect_fetch(8'd29, 16'hA01D, 1'b0);
      tick();
      expect_fetch(8'd30, NOP, 1'b1);
      tick();
      expect_fetch(8'd0, 16'hA000, 1'b0);
      tick();

      // 4: abort together with the second beat
      load_start = 1'b1;
      tick();
      expect_stat(0, 1, 9'd0, 0, 0);
      beat(16'h5555, 1'b0);
      tick();
      beat(16'h6666, 1'b0);
      load_abort = 1'b1;
      tick();
      expect_stat(1, 0, 9'd0, 0, 0);
      expect_fetch(8'd0, NOP, 1'b1);
      tick();
      expect_fetch(8'd1, NOP, 1'b1);
      tick();
      check("abort_word0_written", 32'(dut0.u_array.mem_q[0]), 32'h5555);
      check("abort_word1_kept", 32'(dut0.u_array.mem_q[1]), 32'hA001);

      // 5: reset in the middle of a load, then a clean load
      load_start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         beat(16'h7000 + 16'(i), 1'b0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_stat(1, 0, 9'd0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         expect_fetch(8'(i), NOP, 1'b1);
         tick();
      end
      load_start = 1'b1;
      tick();
      beat(16'h8000, 1'b0);
      tick();
      beat(16'h8001, 1'b1);
      tick();
      expect_stat(1, 0, 9'd2, 0, 1);
      tick();
      expect_fetch(8'd1, 16'h8001, 1'b0);
      tick();
      expect_fetch(8'd2, NOP, 1'b1);
      tick();
      tick();
      tick();

      end_req = 1'b1;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
